// File: rtl/mem_access_unit.sv
// Memory port of the 16-bit multicycle datapath: req/ack access to a variable-latency memory,
// loading Instr/MDR and stalling the control unit. Optional ack timeout: define MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] Instr,
    output logic [DATA_W-1:0] MDR,
    output logic              Stall,
    output logic              MemFault,
    output logic              dbg_state_o
);

    // Handshake: mem_req rises in the cycle after a command is seen in IDLE and stays high,
    // with address/we/wdata stable, up to and including the single cycle in which mem_ack=1.
    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              we_q, we_d;
    logic              tgt_q, tgt_d;
    logic              timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       fault_q;

    assign timeout  = (state_q == S_REQ) && !mem_ack && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign MemFault = fault_q;

    // Counter sits at zero in IDLE, so every REQ entry starts from a cleared count.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) cnt_q <= 8'd0;
            else if (!mem_ack)     cnt_q <= cnt_q + 8'd1;
            if (timeout)           fault_q <= 1'b1;
        end
    end
`else
    assign timeout  = 1'b0;
    assign MemFault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        tgt_d   = tgt_q;
        instr_d = instr_q;
        mdr_d   = mdr_q;
        Stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    Stall   = 1'b1;
                    state_d = S_REQ;
                    addr_d  = IorD ? PC : ALUOut;
                    we_d    = MemWrite;
                    wdata_d = WriteData;
                    tgt_d   = IRWrite;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                    if (!we_q) begin
                        if (tgt_q) instr_d = mem_rdata;
                        else       mdr_d   = mem_rdata;
                    end
                end else if (timeout) begin
                    // An abandoned read leaves a defined zero rather than stale data.
                    state_d = S_IDLE;
                    if (!we_q) begin
                        if (tgt_q) instr_d = '0;
                        else       mdr_d   = '0;
                    end
                end else begin
                    Stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            tgt_q   <= 1'b0;
            instr_q <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
        end
    end

    assign mem_req     = (state_q == S_REQ);
    assign mem_we      = mem_req && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign Instr       = instr_q;
    assign MDR         = mdr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table of memory transactions checked through a scoreboard,
// plus hand sequences for idle ack, timeout (MEM_TIMEOUT_EN) and reset during a request.
module tb_mem_access_unit;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic Reset_n;
    always #5 CLK = ~CLK;

    logic          MemRead, MemWrite, IorD, IRWrite;
    logic [AW-1:0] PC, ALUOut;
    logic [DW-1:0] WriteData;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] Instr, MDR;
    logic          Stall, MemFault, dbg_state;

    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .IRWrite(IRWrite), .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Instr(Instr), .MDR(MDR),
        .Stall(Stall), .MemFault(MemFault), .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [AW+DW:0]  exp_q[$];   // {we, addr, wdata} expected on the request
    logic [2*DW-1:0] res_q[$];   // {Instr, MDR} expected after completion
    logic [DW-1:0]   instr_m, mdr_m;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rd, wr, iord, irw;
        logic [AW-1:0] pc, alu;
        logic [DW-1:0] wd;
        int delay;
        logic [DW-1:0] rdata;
        logic exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, wr, iord, irw, input logic [AW-1:0] pc, alu,
                                input logic [DW-1:0] wd, input int delay, input logic [DW-1:0] rdata,
                                input logic exp_we, input logic [AW-1:0] exp_addr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.iord = iord; v.irw = irw;
        v.pc = pc; v.alu = alu; v.wd = wd; v.delay = delay; v.rdata = rdata;
        v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_wdata = wd;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
        PC = '0; ALUOut = '0; WriteData = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the completing edge.
    task automatic run_txn(input vec_t v);
        logic [AW+DW:0]  e;
        logic [2*DW-1:0] r;
        int stall_cnt = 0;
        int req_cnt   = 0;
        MemRead = v.rd; MemWrite = v.wr; IorD = v.iord; IRWrite = v.irw;
        PC = v.pc; ALUOut = v.alu; WriteData = v.wd;
        exp_q.push_back({v.exp_we, v.exp_addr, v.exp_wdata});
        if (!v.exp_we) begin
            if (v.irw) instr_m = v.rdata;
            else       mdr_m   = v.rdata;
        end
        res_q.push_back({instr_m, mdr_m});
        #1;
        if (Stall === 1'b1) stall_cnt++;
        @(posedge CLK); #1;
        if (exp_q.size() == 0) begin
            check("req_expectation_present", 0, 1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        for (int i = 0; i <= v.delay; i++) begin
            check("mem_we", mem_we, e[AW+DW]);
            check("mem_addr", mem_addr, e[AW+DW-1:DW]);
            check("mem_wdata", mem_wdata, e[DW-1:0]);
            if (i == v.delay) begin
                mem_ack = 1; mem_rdata = v.rdata;
            end else begin
                PC = AW'($urandom_range(0, 65535));
                ALUOut = AW'($urandom_range(0, 65535));
                WriteData = DW'($urandom_range(0, 65535));
            end
            #1;
            if (mem_req === 1'b1) req_cnt++;
            if (Stall === 1'b1) stall_cnt++;
            @(posedge CLK); #1;
        end
        mem_ack = 0; MemRead = 0; MemWrite = 0;
        mem_rdata = DW'($urandom_range(0, 65535));
        check("req_after_ack", mem_req, 0);
        check("req_cycles", req_cnt, v.delay + 1);
        check("stall_cycles", stall_cnt, v.delay + 1);
        if (res_q.size() == 0) begin
            check("res_expectation_present", 0, 1);
        end else begin
            r = res_q.pop_front();
            check("Instr", Instr, r[2*DW-1:DW]);
            check("MDR", MDR, r[DW-1:0]);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [AW-1:0] pc_r, alu_r;
        logic [DW-1:0] wd_r, rd_r;
        logic iord_r, irw_r, wr_r;
        instr_m = '0; mdr_m = '0;
        idle_inputs();
        Reset_n = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_Instr", Instr, 0);
        check("rst_MDR", MDR, 0);
        check("rst_Stall", Stall, 0);
        check("rst_MemFault", MemFault, 0);
        Reset_n = 1;
        @(posedge CLK); #1;

        // fetch, load, store, read+write collision
        vecs.push_back(mk(1, 0, 1, 1, 16'h0010, 16'h0555, 16'h7777, 2, 16'h2C41, 0, 16'h0010));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0012, 16'h0200, 16'h0000, 0, 16'hBEEF, 0, 16'h0200));
        vecs.push_back(mk(0, 1, 0, 1, 16'h0014, 16'h0300, 16'h1234, 1, 16'hDEAD, 1, 16'h0300));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0016, 16'h0400, 16'h00FF, 0, 16'h5555, 1, 16'h0400));
`ifndef MEM_TIMEOUT_EN
        vecs.push_back(mk(1, 0, 1, 1, 16'h0020, 16'h0001, 16'h0000, 20, 16'h0F0F, 0, 16'h0020));
`endif
        for (int k = 0; k < 8; k++) begin
            pc_r = AW'($urandom_range(0, 65535)); alu_r = AW'($urandom_range(0, 65535));
            wd_r = DW'($urandom_range(0, 65535)); rd_r = DW'($urandom_range(0, 65535));
            iord_r = 1'($urandom_range(0, 1)); irw_r = 1'($urandom_range(0, 1));
            wr_r = 1'($urandom_range(0, 1));
            vecs.push_back(mk(!wr_r, wr_r, iord_r, irw_r, pc_r, alu_r, wd_r,
                              $urandom_range(0, 2), rd_r, wr_r, iord_r ? pc_r : alu_r));
        end
        foreach (vecs[k]) run_txn(vecs[k]);

        // IDLE: outputs hold, a stray ack changes nothing
        pc_r = mem_addr; wd_r = mem_wdata;
        @(posedge CLK); #1;
        mem_ack = 1; mem_rdata = 16'hA5A5;
        @(posedge CLK); #1;
        mem_ack = 0;
        check("idle_req", mem_req, 0);
        check("idle_we", mem_we, 0);
        check("idle_addr_hold", mem_addr, pc_r);
        check("idle_wdata_hold", mem_wdata, wd_r);
        check("idle_ack_Instr", Instr, instr_m);
        check("idle_ack_MDR", MDR, mdr_m);
        check("idle_Stall", Stall, 0);

`ifdef MEM_TIMEOUT_EN
        run_txn(mk(1, 0, 0, 0, 16'h0000, 16'h0500, 16'h0000, 0, 16'h1111, 0, 16'h0500));
        MemRead = 1; IorD = 0; IRWrite = 0; ALUOut = 16'h0600;
        @(posedge CLK); #1;
        for (int i = 0; i < TO; i++) begin
            check("to_req_high", mem_req, 1);
            check("to_stall", Stall, (i < TO - 1) ? 1 : 0);
            @(posedge CLK); #1;
        end
        MemRead = 0;
        mdr_m = '0;
        check("to_req_dropped", mem_req, 0);
        check("to_MemFault", MemFault, 1);
        check("to_MDR_zero", MDR, 16'h0000);
        check("to_Instr_hold", Instr, instr_m);
        @(posedge CLK); #1;
        check("to_MemFault_sticky", MemFault, 1);
`endif

        // reset while a request is outstanding
        MemRead = 1; IorD = 1; IRWrite = 1; PC = 16'h0040;
        @(posedge CLK); #1;
        check("pre_rst_req", mem_req, 1);
        Reset_n = 0; #1;
        check("mid_rst_req_drop", mem_req, 0);
        MemRead = 0; #1;
        Reset_n = 1;
        instr_m = '0; mdr_m = '0;
        check("mid_rst_Instr", Instr, 0);
        check("mid_rst_MDR", MDR, 0);
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_MemFault", MemFault, 0);
        @(posedge CLK); #1;
        mem_ack = 1; mem_rdata = 16'hCAFE;
        @(posedge CLK); #1;
        mem_ack = 0;
        check("late_ack_Instr", Instr, instr_m);
        check("late_ack_MDR", MDR, mdr_m);
        check("late_ack_req", mem_req, 0);

        // normal operation resumes after reset
        run_txn(mk(1, 0, 1, 1, 16'h0042, 16'h0000, 16'h0000, 1, 16'h8001, 0, 16'h0042));

        check("scoreboard_drained", exp_q.size() + res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
